// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: banked single-port RAM with a CPU port and per-bank read-only secondary ports.
// Define BANKED_MEM_STARVE_GUARD_EN to build starvation counters that bound CPU stalls to STARVE_LIMIT cycles.
module memory #(
    parameter int BITS = 16,
    parameter int AW   = 14
) (
    input  logic            CLK,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] dout
);
    logic [BITS-1:0] mem [2**AW];
    always_ff @(posedge CLK) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end
endmodule

module banked_mem_ctrl #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int BANK_BITS    = 2,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                                                 CLK,
    input  logic                                                 RSTb,
    input  logic [ADDRESS_BITS-1:0]                              ADDRESS,
    input  logic [BITS-1:0]                                      DATA_IN,
    input  logic                                                 memWR,
    input  logic                                                 memRD,
    output logic [BITS-1:0]                                      DATA_OUT,
    output logic                                                 memBUSY,
    output logic                                                 CPU_VALID,
    input  logic [2**BANK_BITS-1:0]                              B_RD,
    input  logic [(2**BANK_BITS)*(ADDRESS_BITS-BANK_BITS)-1:0]   B_ADDR,
    output logic [2**BANK_BITS-1:0]                              B_GNT,
    output logic [(2**BANK_BITS)*BITS-1:0]                       B_DOUT,
    output logic [2**BANK_BITS-1:0]                              B_VALID
);
    localparam int NB = 2**BANK_BITS;
    localparam int OW = ADDRESS_BITS - BANK_BITS;

    logic [BANK_BITS-1:0]      bank;
    logic                      cpu_req;
    logic [NB-1:0]             cpu_req_b, cpu_win, force_cpu;
    logic [NB-1:0][BITS-1:0]   rdata, b_dout, b_dout_q, b_dout_d;
    logic [NB-1:0]             b_valid_q, b_valid_d;
    logic                      cpu_valid_q, cpu_valid_d;
    logic [BANK_BITS-1:0]      bank_sel_q, bank_sel_d;
    logic [BITS-1:0]           data_out_q, data_out_d;

    assign bank    = ADDRESS[ADDRESS_BITS-1 -: BANK_BITS];
    assign cpu_req = memRD | memWR;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            cpu_req_b[i] = cpu_req && (bank == BANK_BITS'(i));
            cpu_win[i]   = cpu_req_b[i] && (!B_RD[i] || force_cpu[i]);
        end
    end

`ifdef BANKED_MEM_STARVE_GUARD_EN
    logic [NB-1:0][7:0] starve_q, starve_d;
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            force_cpu[i] = starve_q[i] == 8'(STARVE_LIMIT);
            starve_d[i]  = (cpu_req_b[i] && !cpu_win[i]) ?
                           (force_cpu[i] ? starve_q[i] : starve_q[i] + 8'd1) : 8'd0;
        end
    end
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_cpu = '0;
`endif

    for (genvar i = 0; i < NB; i++) begin : g_bank
        memory #(.BITS(BITS), .AW(OW)) u_mem (
            .CLK  (CLK),
            .we   (cpu_win[i] && memWR),
            .addr (cpu_win[i] ? ADDRESS[OW-1:0] : B_ADDR[i*OW +: OW]),
            .din  (DATA_IN),
            .dout (rdata[i])
        );
    end

    assign memBUSY   = cpu_req && !cpu_win[bank];
    assign B_GNT     = B_RD & ~cpu_win;
    assign CPU_VALID = cpu_valid_q;
    assign B_VALID   = b_valid_q;
    // Read data passes straight from the RAM in the valid cycle, then is held in the _q copy.
    assign DATA_OUT  = cpu_valid_q ? rdata[bank_sel_q] : data_out_q;
    assign B_DOUT    = b_dout;

    always_comb begin
        for (int i = 0; i < NB; i++) b_dout[i] = b_valid_q[i] ? rdata[i] : b_dout_q[i];
    end

    always_comb begin
        cpu_valid_d = memRD && !memWR && !memBUSY;
        bank_sel_d  = cpu_valid_d ? bank : bank_sel_q;
        data_out_d  = DATA_OUT;
        b_valid_d   = B_GNT;
        b_dout_d    = b_dout;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cpu_valid_q <= 1'b0;
            bank_sel_q  <= '0;
            data_out_q  <= '0;
            b_valid_q   <= '0;
            b_dout_q    <= '0;
        end else begin
            cpu_valid_q <= cpu_valid_d;
            bank_sel_q  <= bank_sel_d;
            data_out_q  <= data_out_d;
            b_valid_q   <= b_valid_d;
            b_dout_q    <= b_dout_d;
        end
    end
endmodule

// File: tb/tb_banked_mem_ctrl.sv
// tb_banked_mem_ctrl: directed self-checking bench for banked_mem_ctrl (default parameters).
module tb_banked_mem_ctrl;
    logic        CLK = 1'b0;
    logic        RSTb;
    logic [15:0] ADDRESS, DATA_IN, DATA_OUT;
    logic        memWR, memRD, memBUSY, CPU_VALID;
    logic [3:0]  B_RD, B_GNT, B_VALID;
    logic [55:0] B_ADDR;
    logic [63:0] B_DOUT;
    int total = 0;
    int bad = 0;

    banked_mem_ctrl dut (
        .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
        .memWR(memWR), .memRD(memRD), .DATA_OUT(DATA_OUT), .memBUSY(memBUSY),
        .CPU_VALID(CPU_VALID), .B_RD(B_RD), .B_ADDR(B_ADDR), .B_GNT(B_GNT),
        .B_DOUT(B_DOUT), .B_VALID(B_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ADDRESS = 16'h0; DATA_IN = 16'h0; memWR = 1'b0; memRD = 1'b0;
        B_RD = 4'h0; B_ADDR = '0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        idle();
        ADDRESS = a; DATA_IN = d; memWR = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ADDRESS = 16'($urandom); DATA_IN = 16'($urandom);
            memWR = 1'($urandom); memRD = 1'($urandom);
            B_RD = 4'($urandom); B_ADDR = {$urandom, $urandom};
            cyc();
        end
        total++; if (DATA_OUT !== 16'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0000", DATA_OUT); end
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL reset_cpu_valid got=%b exp=0", CPU_VALID); end
        total++; if (B_VALID !== 4'h0) begin bad++; $display("FAIL reset_b_valid got=%h exp=0", B_VALID); end
        total++; if (B_DOUT !== 64'h0) begin bad++; $display("FAIL reset_b_dout got=%h exp=0", B_DOUT); end
        idle();
        @(negedge CLK);
        RSTb = 1'b1;
        cyc();
        ADDRESS = 16'h0005; memRD = 1'b1;
        #1;
        total++; if (memBUSY !== 1'b0) begin bad++; $display("FAIL reset_read_busy got=%b exp=0", memBUSY); end
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL reset_read_early got=%b exp=0", CPU_VALID); end
        cyc();
        idle();
        total++; if (CPU_VALID !== 1'b1) begin bad++; $display("FAIL reset_read_valid got=%b exp=1", CPU_VALID); end
        cyc();
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL reset_read_pulse got=%b exp=0", CPU_VALID); end
    endtask

    task automatic test_write_read();
        idle();
        ADDRESS = 16'h4123; DATA_IN = 16'hBEEF; memWR = 1'b1;
        #1;
        total++; if (memBUSY !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", memBUSY); end
        cyc();
        memWR = 1'b0; memRD = 1'b1; DATA_IN = 16'h0;
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL wr_no_valid got=%b exp=0", CPU_VALID); end
        total++; if (memBUSY !== 1'b0) begin bad++; $display("FAIL rd_busy got=%b exp=0", memBUSY); end
        cyc();
        idle();
        total++; if (CPU_VALID !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b exp=1", CPU_VALID); end
        total++; if (DATA_OUT !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=beef", DATA_OUT); end
        cyc(); cyc();
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL rd_pulse got=%b exp=0", CPU_VALID); end
        total++; if (DATA_OUT !== 16'hBEEF) begin bad++; $display("FAIL rd_hold got=%h exp=beef", DATA_OUT); end
    endtask

    task automatic test_conflict();
        cpu_write(16'h8010, 16'h1234);
        ADDRESS = 16'h8010; memRD = 1'b1;
        B_RD = 4'b0100; B_ADDR[2*14 +: 14] = 14'h0010;
        #1;
        total++; if (memBUSY !== 1'b1) begin bad++; $display("FAIL conf_busy got=%b exp=1", memBUSY); end
        total++; if (B_GNT !== 4'b0100) begin bad++; $display("FAIL conf_gnt got=%b exp=0100", B_GNT); end
        cyc();
        total++; if (B_VALID !== 4'b0100) begin bad++; $display("FAIL conf_b_valid got=%b exp=0100", B_VALID); end
        total++; if (B_DOUT[32 +: 16] !== 16'h1234) begin bad++; $display("FAIL conf_b_dout got=%h exp=1234", B_DOUT[32 +: 16]); end
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL conf_cpu_early got=%b exp=0", CPU_VALID); end
        B_RD = 4'b0000;
        #1;
        total++; if (memBUSY !== 1'b0) begin bad++; $display("FAIL conf_release got=%b exp=0", memBUSY); end
        total++; if (B_GNT !== 4'b0000) begin bad++; $display("FAIL conf_gnt_idle got=%b exp=0000", B_GNT); end
        cyc();
        idle();
        total++; if (CPU_VALID !== 1'b1) begin bad++; $display("FAIL conf_cpu_valid got=%b exp=1", CPU_VALID); end
        total++; if (DATA_OUT !== 16'h1234) begin bad++; $display("FAIL conf_cpu_data got=%h exp=1234", DATA_OUT); end
        total++; if (B_VALID !== 4'b0000) begin bad++; $display("FAIL conf_b_pulse got=%b exp=0000", B_VALID); end
        total++; if (B_DOUT[32 +: 16] !== 16'h1234) begin bad++; $display("FAIL conf_b_hold got=%h exp=1234", B_DOUT[32 +: 16]); end
    endtask

    task automatic test_starvation();
        int busy_cycles = 0;
        int valid_seen = 0;
        cpu_write(16'h4000, 16'hA5A5);
        ADDRESS = 16'h4000; memRD = 1'b1;
        B_RD = 4'b0010; B_ADDR[1*14 +: 14] = 14'h0000;
`ifdef BANKED_MEM_STARVE_GUARD_EN
        while (busy_cycles < 20) begin
            #1;
            if (!memBUSY) break;
            busy_cycles++;
            cyc();
        end
        total++; if (busy_cycles !== 7) begin bad++; $display("FAIL starve_busy_cycles got=%0d exp=7", busy_cycles); end
        total++; if (B_GNT !== 4'b0000) begin bad++; $display("FAIL starve_gnt got=%b exp=0000", B_GNT); end
        cyc();
        memRD = 1'b0;
        #1;
        total++; if (CPU_VALID !== 1'b1) begin bad++; $display("FAIL starve_valid got=%b exp=1", CPU_VALID); end
        total++; if (DATA_OUT !== 16'hA5A5) begin bad++; $display("FAIL starve_data got=%h exp=a5a5", DATA_OUT); end
        total++; if (B_VALID[1] !== 1'b0) begin bad++; $display("FAIL starve_b_valid got=%b exp=0", B_VALID[1]); end
`else
        for (int k = 0; k < 100; k++) begin
            #1;
            if (memBUSY) busy_cycles++;
            if (CPU_VALID) valid_seen++;
            cyc();
        end
        total++; if (busy_cycles !== 100) begin bad++; $display("FAIL starve_busy_cycles got=%0d exp=100", busy_cycles); end
        total++; if (valid_seen !== 0) begin bad++; $display("FAIL starve_no_valid got=%0d exp=0", valid_seen); end
        total++; if (B_VALID !== 4'b0010) begin bad++; $display("FAIL starve_b_valid got=%b exp=0010", B_VALID); end
`endif
        idle();
        cyc();
    endtask

    task automatic test_parallel();
        idle();
        ADDRESS = 16'hC007; DATA_IN = 16'h7777; memWR = 1'b1;
        B_RD = 4'b0111;
        B_ADDR[0*14 +: 14] = 14'h0005;
        B_ADDR[1*14 +: 14] = 14'h0123;
        B_ADDR[2*14 +: 14] = 14'h0010;
        #1;
        total++; if (memBUSY !== 1'b0) begin bad++; $display("FAIL par_busy got=%b exp=0", memBUSY); end
        total++; if (B_GNT !== 4'b0111) begin bad++; $display("FAIL par_gnt got=%b exp=0111", B_GNT); end
        cyc();
        idle();
        ADDRESS = 16'hC007; memRD = 1'b1;
        total++; if (B_VALID !== 4'b0111) begin bad++; $display("FAIL par_b_valid got=%b exp=0111", B_VALID); end
        total++; if (B_DOUT[16 +: 16] !== 16'hBEEF) begin bad++; $display("FAIL par_b1_dout got=%h exp=beef", B_DOUT[16 +: 16]); end
        total++; if (B_DOUT[32 +: 16] !== 16'h1234) begin bad++; $display("FAIL par_b2_dout got=%h exp=1234", B_DOUT[32 +: 16]); end
        cyc();
        idle();
        total++; if (DATA_OUT !== 16'h7777) begin bad++; $display("FAIL par_raw_data got=%h exp=7777", DATA_OUT); end
        cyc();
    endtask

    task automatic test_async_reset();
        int busy_cycles = 0;
        idle();
        ADDRESS = 16'h4123; memRD = 1'b1;
        cyc();
        idle();
        total++; if (CPU_VALID !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b exp=1", CPU_VALID); end
        RSTb = 1'b0;
        #1;
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL arst_valid_drop got=%b exp=0", CPU_VALID); end
        total++; if (DATA_OUT !== 16'h0) begin bad++; $display("FAIL arst_data got=%h exp=0000", DATA_OUT); end
        #1;
        RSTb = 1'b1;
        cyc();
        total++; if (CPU_VALID !== 1'b0) begin bad++; $display("FAIL arst_no_complete got=%b exp=0", CPU_VALID); end
`ifdef BANKED_MEM_STARVE_GUARD_EN
        ADDRESS = 16'h4000; memRD = 1'b1; B_RD = 4'b0010;
        cyc(); cyc(); cyc();
        RSTb = 1'b0;
        #1;
        RSTb = 1'b1;
        while (busy_cycles < 20) begin
            #1;
            if (!memBUSY) break;
            busy_cycles++;
            cyc();
        end
        total++; if (busy_cycles !== 7) begin bad++; $display("FAIL arst_counter_clear got=%0d exp=7", busy_cycles); end
        idle();
        cyc();
`endif
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_conflict();
        test_starvation();
        test_parallel();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/banked_mem_ctrl.md
# banked_mem_ctrl

Parametrised, arbitrated banked RAM controller for the CPU data bus. It splits on-chip RAM into 2^BANK_BITS single-port banks and gives each bank a second, read-only requester port for the graphics/audio fetch engines. Per-bank arbitration drives a real `memBUSY` stall back to the CPU, and read completion is flagged with a valid strobe. It sits behind the top-level address decoder, which routes the RAM window here and keeps peripheral decode elsewhere.

## Interface

**Parameters**

- `BITS`, 16: data word width.
- `ADDRESS_BITS`, 16: CPU word-address width into this block.
- `BANK_BITS`, 2: bank select width.
  - Bank = `ADDRESS[ADDRESS_BITS-1 -: BANK_BITS]`.
  - Bank depth = 2^(ADDRESS_BITS-BANK_BITS) words.
- `STARVE_LIMIT`, 7: consecutive lost CPU cycles on one bank before the CPU is forced through. Legal range is 1..255.

**Ports** (NB = 2^BANK_BITS, OW = ADDRESS_BITS-BANK_BITS)

- `CLK` in 1: system clock.
- `RSTb` in 1: reset; asynchronous assert, active-low.
- `ADDRESS` in ADDRESS_BITS: CPU word address.
- `DATA_IN` in BITS: CPU write data.
- `memWR` in 1: CPU write request.
- `memRD` in 1: CPU read request.
- `DATA_OUT` out BITS: CPU read data; held between reads.
- `memBUSY` out 1: combinational stall; the CPU holds address, data and strobe while it is high.
- `CPU_VALID` out 1: one-cycle pulse marking `DATA_OUT` valid.
- `B_RD` in NB: per-bank secondary read request.
- `B_ADDR` in NB*OW: per-bank secondary address, flattened; bank i uses `[i*OW +: OW]`.
- `B_GNT` out NB: combinational grant for the secondary port.
- `B_DOUT` out NB*BITS: per-bank secondary read data, flattened.
- `B_VALID` out NB: per-bank secondary data-valid pulse.

## Operation

- Each bank is one `memory` instance (single port, synchronous read, OW address bits). Contents are not touched by reset.
- CPU request for bank b: `(memRD|memWR)` with `ADDRESS` in bank b. If `memRD` and `memWR` are both high, the write wins and no read is issued.
- Per-bank arbitration is combinational, each cycle:
  - Only one requester: it wins.
  - Both request: the secondary wins, unless `starve_cnt[b] == STARVE_LIMIT` (guard build only), in which case the CPU wins.
- Winner drives the bank address, write-enable and data. A secondary can only read.
- `memBUSY` = CPU request present and the CPU lost bank b this cycle.
- `B_GNT[i]` = `B_RD[i]` and the secondary won bank i. A denied secondary holds `B_RD` and `B_ADDR`.
- CPU write commits at the clock edge in which `memWR` is high and `memBUSY` is low. There is no `CPU_VALID` for writes.
- Starvation counter `starve_cnt[b]` (8-bit, guard build only):
  - +1 each cycle the CPU loses bank b.
  - Cleared to 0 when the CPU wins bank b or has no request to it.
  - Saturates at `STARVE_LIMIT`.

## Timing

- Reset values: `DATA_OUT`=0, `CPU_VALID`=0, `B_VALID`=0, `B_DOUT`=0, all `starve_cnt`=0, registered bank select=0.
- `memBUSY` and `B_GNT` are combinational from the current inputs. They read as 0 when there is no request.
- CPU read accepted at edge N gives `CPU_VALID`=1 and `DATA_OUT` valid in cycle N+1 (one-cycle latency).
  - The registered bank select steers the RAM output mux.
  - `DATA_OUT` holds the value in a register until the next `CPU_VALID`.
- Secondary read granted at edge N gives `B_VALID[i]`=1 and `B_DOUT[i]` valid in cycle N+1. `B_DOUT` holds until the next grant.
- Back-to-back accepted reads sustain one word per cycle per bank. CPU and secondary accesses to different banks proceed in the same cycle.
- Read-after-write to the same address in the next cycle returns the new data.
- Reset asserted mid-transaction: all valid pulses are dropped immediately and counters clear. No pending read completes after `RSTb` rises.

## Configuration

- `BANKED_MEM_STARVE_GUARD_EN` defined:
  - Starvation counters are built.
  - The CPU is guaranteed bank access after at most `STARVE_LIMIT` consecutive stall cycles.
- Not defined:
  - No counters.
  - The secondary always wins conflicts, so the CPU may stall indefinitely while `B_RD[b]` is held.

## Test plan

- **Reset:** hold `RSTb`=0 with random inputs → all outputs 0; release, CPU read of bank 0 addr 0x0005 → `CPU_VALID` one cycle later.
- **CPU write/read:** write 0xBEEF to 0x4123, then read 0x4123 → no `memBUSY`, `DATA_OUT`=0xBEEF one cycle after the read, held afterwards.
- **Conflict:** CPU read of 0x8010 with `B_RD[2]`=1 at offset 0x0010 → `memBUSY`=1, `B_GNT[2]`=1, `B_VALID[2]` next cycle; CPU completes when `B_RD[2]` drops.
- **Starvation (guard on, `STARVE_LIMIT`=7):** hold `B_RD[1]`=1 and CPU read of 0x4000 → `memBUSY` high for 7 cycles, CPU wins the 8th with `B_GNT[1]`=0, `CPU_VALID` next cycle; guard off → `memBUSY` stays high for 100 cycles.
- **Parallel banks:** CPU write to bank 3 while secondaries read banks 0–2 → all granted, no busy, `B_VALID[2:0]`=3'b111 next cycle.
- **Async reset mid-read:** pulse `RSTb` low between accept and data → `CPU_VALID` stays 0, counters 0.
